// File: rtl/lc3_memory.sv
// LC3 external-bus memory slave: independent fetch and data ports with fixed response latencies.
// Optional LC3_MEM_OOR_TRAP_EN traps out-of-range accesses instead of wrapping the index.
module lc3_memory #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [15:0] BASE_ADDR = 16'h3000,
  parameter int unsigned INSTR_LAT = 1,
  parameter int unsigned DATA_LAT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic [15:0] Data_addr,
  input  logic        data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        oor_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [AW-1:0] to_idx(input logic [15:0] a);
    to_idx = AW'(a - BASE_ADDR);
  endfunction

  function automatic logic in_range(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE_ADDR;
    in_range = (off < 16'(DEPTH));
  endfunction

  logic [15:0]   mem [DEPTH];
  state_t        f_state, d_state;
  logic [CW-1:0] f_cnt, d_cnt;
  logic [AW-1:0] f_idx, d_idx;
  logic          d_rd;
  logic [15:0]   d_wdata;
  logic [15:0]   f_word, d_word;
  logic          d_we, ld_we;

`ifdef LC3_MEM_OOR_TRAP_EN
  logic f_oor, d_oor;

  assign f_word = f_oor ? 16'hF025 : mem[f_idx];
  assign d_word = d_oor ? 16'h0000 : mem[d_idx];
  assign d_we   = (d_state == DONE) && !d_rd && !d_oor && !reset;

  // Sticky flag: set by any out-of-range completion, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      oor_err <= 1'b0;
    end else if ((f_state == DONE && f_oor) || (d_state == DONE && d_oor)) begin
      oor_err <= 1'b1;
    end
  end
`else
  assign f_word  = mem[f_idx];
  assign d_word  = mem[d_idx];
  assign d_we    = (d_state == DONE) && !d_rd && !reset;
  assign oor_err = 1'b0;
`endif

  assign ld_we = load_en && in_range(load_addr);

  // Preload is written after the data write so it wins on a same-index collision.
  always_ff @(posedge clock) begin
    if (d_we) begin
      mem[d_idx] <= d_wdata;
    end
    if (ld_we) begin
      mem[to_idx(load_addr)] <= load_data;
    end
  end

  // Fetch port: address captured at accept, read-before-write against same-cycle stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_state        <= IDLE;
      f_cnt          <= '0;
      f_idx          <= '0;
      Instr_dout     <= '0;
      complete_instr <= 1'b0;
`ifdef LC3_MEM_OOR_TRAP_EN
      f_oor          <= 1'b0;
`endif
    end else begin
      complete_instr <= 1'b0;
      case (f_state)
        IDLE: begin
          if (instrmem_rd) begin
            f_idx   <= to_idx(pc);
            f_cnt   <= CW'(INSTR_LAT - 1);
            f_state <= (INSTR_LAT == 1) ? DONE : BUSY;
`ifdef LC3_MEM_OOR_TRAP_EN
            f_oor   <= !in_range(pc);
`endif
          end
        end
        BUSY: begin
          f_cnt <= f_cnt - CW'(1);
          if (f_cnt == CW'(1)) begin
            f_state <= DONE;
          end
        end
        DONE: begin
          Instr_dout     <= f_word;
          complete_instr <= 1'b1;
          f_state        <= IDLE;
        end
        default: f_state <= IDLE;
      endcase
    end
  end

  // Data port: address, direction and write data captured at accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_state       <= IDLE;
      d_cnt         <= '0;
      d_idx         <= '0;
      d_rd          <= 1'b0;
      d_wdata       <= '0;
      Data_dout     <= '0;
      complete_data <= 1'b0;
`ifdef LC3_MEM_OOR_TRAP_EN
      d_oor         <= 1'b0;
`endif
    end else begin
      complete_data <= 1'b0;
      case (d_state)
        IDLE: begin
          if (data_en) begin
            d_idx   <= to_idx(Data_addr);
            d_rd    <= Data_rd;
            d_wdata <= Data_din;
            d_cnt   <= CW'(DATA_LAT - 1);
            d_state <= (DATA_LAT == 1) ? DONE : BUSY;
`ifdef LC3_MEM_OOR_TRAP_EN
            d_oor   <= !in_range(Data_addr);
`endif
          end
        end
        BUSY: begin
          d_cnt <= d_cnt - CW'(1);
          if (d_cnt == CW'(1)) begin
            d_state <= DONE;
          end
        end
        DONE: begin
          if (d_rd) begin
            Data_dout <= d_word;
          end
          complete_data <= 1'b1;
          d_state       <= IDLE;
        end
        default: d_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_memory.sv
// Scoreboard bench for lc3_memory: a default-latency instance and an INSTR_LAT=3/DATA_LAT=3 instance.
module tb_lc3_memory;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, instrmem_rd, complete_instr, data_en, data_rd, complete_data, load_en, oor_err;
  logic [15:0] pc, instr_dout, data_addr, data_din, data_dout, load_addr, load_data;
  logic        reset3, instrmem_rd3, complete_instr3, data_en3, data_rd3, complete_data3, load_en3, oor_err3;
  logic [15:0] pc3, instr_dout3, data_addr3, data_din3, data_dout3, load_addr3, load_data3;

  int checks = 0;
  int passed = 0;
  logic [15:0] instr_q[$];
  logic [15:0] data_q[$];
  logic [15:0] instr3_q[$];
  logic [15:0] data3_q[$];
  logic [15:0] last_rd = 16'h0000;

  localparam logic [15:0] FA [4] = '{16'h3000, 16'h3001, 16'h30FE, 16'h30FF};
  localparam logic [15:0] FV [4] = '{16'h1261, 16'hABCD, 16'h0042, 16'h7777};
  localparam logic [15:0] DA [5] = '{16'h3010, 16'h3011, 16'h3010, 16'h3011, 16'h3000};
  localparam logic        DR [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [15:0] DV [5] = '{16'hBEEF, 16'h1357, 16'hBEEF, 16'h1357, 16'h1261};
  localparam logic [15:0] BA [4] = '{16'h3040, 16'h3041, 16'h3042, 16'h3043};
  localparam logic [15:0] BV [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hDEAD};
`ifdef LC3_MEM_OOR_TRAP_EN
  localparam logic [15:0] OOR_WORD = 16'hF025;
  localparam logic        OOR_FLAG = 1'b1;
`else
  localparam logic [15:0] OOR_WORD = 16'h7777;
  localparam logic        OOR_FLAG = 1'b0;
`endif

  lc3_memory u_dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(instr_dout), .complete_instr(complete_instr),
    .Data_addr(data_addr), .data_en(data_en), .Data_rd(data_rd), .Data_din(data_din),
    .Data_dout(data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .oor_err(oor_err)
  );

  lc3_memory #(.INSTR_LAT(3), .DATA_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset3), .pc(pc3), .instrmem_rd(instrmem_rd3),
    .Instr_dout(instr_dout3), .complete_instr(complete_instr3),
    .Data_addr(data_addr3), .data_en(data_en3), .Data_rd(data_rd3), .Data_din(data_din3),
    .Data_dout(data_dout3), .complete_data(complete_data3),
    .load_en(load_en3), .load_addr(load_addr3), .load_data(load_data3), .oor_err(oor_err3)
  );

  // All stimulus tasks start and end on a falling edge.
  task automatic load(input int which, input logic [15:0] a, input logic [15:0] d);
    if (which == 0) begin load_en = 1'b1; load_addr = a; load_data = d; end
    else begin load_en3 = 1'b1; load_addr3 = a; load_data3 = d; end
    @(negedge clock);
    load_en = 1'b0; load_en3 = 1'b0;
  endtask

  task automatic fetch_go(input int which, input logic [15:0] a);
    if (which == 0) begin pc = a; instrmem_rd = 1'b1; end
    else begin pc3 = a; instrmem_rd3 = 1'b1; end
    @(negedge clock);
    instrmem_rd = 1'b0; instrmem_rd3 = 1'b0;
    pc = ~a; pc3 = ~a;
  endtask

  task automatic data_go(input int which, input logic [15:0] a, input logic rd, input logic [15:0] din);
    if (which == 0) begin data_addr = a; data_rd = rd; data_din = din; data_en = 1'b1; end
    else begin data_addr3 = a; data_rd3 = rd; data_din3 = din; data_en3 = 1'b1; end
    @(negedge clock);
    data_en = 1'b0; data_en3 = 1'b0;
    data_addr = ~a; data_addr3 = ~a; data_din = ~din; data_din3 = ~din; data_rd = ~rd; data_rd3 = ~rd;
  endtask

  // Counts falling edges until the selected completion pulse is seen, bounded.
  task automatic wait_done(input int sel, output bit ok, output int k);
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 20) begin
      @(negedge clock);
      k++;
      case (sel)
        0: ok = complete_instr;
        1: ok = complete_data;
        2: ok = complete_instr3;
        default: ok = complete_data3;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = '0; instrmem_rd = 1'b0; data_addr = '0; data_en = 1'b0; data_rd = 1'b0;
    data_din = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    reset3 = 1'b1; pc3 = '0; instrmem_rd3 = 1'b0; data_addr3 = '0; data_en3 = 1'b0; data_rd3 = 1'b0;
    data_din3 = '0; load_en3 = 1'b0; load_addr3 = '0; load_data3 = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({instr_dout, data_dout, complete_instr, complete_data, oor_err} !== 35'd0)
      $display("FAIL reset_outputs: got %h expected 0", {instr_dout, data_dout, complete_instr, complete_data, oor_err});
    else passed++;
    checks++;
    if ({instr_dout3, data_dout3, complete_instr3, complete_data3, oor_err3} !== 35'd0)
      $display("FAIL reset_outputs3: got %h expected 0", {instr_dout3, data_dout3, complete_instr3, complete_data3, oor_err3});
    else passed++;
    reset = 1'b0; reset3 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_fetch();
    bit ok; int k; logic [15:0] e;
    for (int i = 0; i < 4; i++) load(0, FA[i], FV[i]);
    for (int i = 0; i < 4; i++) begin
      fetch_go(0, FA[i]);
      instr_q.push_back(FV[i]);
      wait_done(0, ok, k);
      checks++;
      if (!ok || k != 1) $display("FAIL fetch_latency: got %0d cycles (done=%0b) expected 1", k, ok);
      else passed++;
      e = instr_q.pop_front();
      checks++;
      if (instr_dout !== e) $display("FAIL fetch_data: got %h expected %h", instr_dout, e);
      else passed++;
      @(negedge clock);
      checks++;
      if ({complete_instr, instr_dout} !== {1'b0, e})
        $display("FAIL fetch_hold: got pulse=%b data=%h expected pulse=0 data=%h", complete_instr, instr_dout, e);
      else passed++;
    end
  endtask

  task automatic test_data();
    bit ok; int k; logic [15:0] e;
    for (int i = 0; i < 5; i++) begin
      data_go(0, DA[i], DR[i], DV[i]);
      if (DR[i]) last_rd = DV[i];
      data_q.push_back(last_rd);
      wait_done(1, ok, k);
      checks++;
      if (!ok || k != 2) $display("FAIL data_latency: got %0d cycles (done=%0b) expected 2", k, ok);
      else passed++;
      e = data_q.pop_front();
      checks++;
      if (data_dout !== e) $display("FAIL data_dout: got %h expected %h (op %0d)", data_dout, e, i);
      else passed++;
    end
  endtask

  task automatic test_collision();
    bit ok; int k; logic [15:0] e;
    // Fetch DONE aligned with write DONE on the same word.
    load(0, 16'h3004, 16'h5020);
    data_addr = 16'h3004; data_rd = 1'b0; data_din = 16'h0000; data_en = 1'b1;
    @(negedge clock);
    data_en = 1'b0; data_din = 16'hFFFF; pc = 16'h3004; instrmem_rd = 1'b1;
    instr_q.push_back(16'h5020);
    @(negedge clock);
    instrmem_rd = 1'b0;
    @(negedge clock);
    checks++;
    if ({complete_instr, complete_data} !== 2'b11) $display("FAIL collide_align: got %b expected 11", {complete_instr, complete_data});
    else passed++;
    e = instr_q.pop_front();
    checks++;
    if (instr_dout !== e) $display("FAIL collide_rbw: got %h expected %h", instr_dout, e);
    else passed++;
    fetch_go(0, 16'h3004); instr_q.push_back(16'h0000); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || instr_dout !== e) $display("FAIL collide_after_write: got %h expected %h", instr_dout, e);
    else passed++;

    // Preload and data write committing on the same edge: preload wins.
    data_addr = 16'h3005; data_rd = 1'b0; data_din = 16'h1111; data_en = 1'b1;
    @(negedge clock);
    data_en = 1'b0;
    @(negedge clock);
    load_en = 1'b1; load_addr = 16'h3005; load_data = 16'h2222;
    @(negedge clock);
    load_en = 1'b0;
    checks++;
    if (complete_data !== 1'b1) $display("FAIL load_vs_write_align: got %b expected 1", complete_data);
    else passed++;
    fetch_go(0, 16'h3005); instr_q.push_back(16'h2222); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || instr_dout !== e) $display("FAIL load_vs_write: got %h expected %h", instr_dout, e);
    else passed++;

    // Preload and fetch completing on the same edge: fetch sees the old word.
    load(0, 16'h3006, 16'hAAAA);
    pc = 16'h3006; instrmem_rd = 1'b1; instr_q.push_back(16'hAAAA);
    @(negedge clock);
    instrmem_rd = 1'b0; load_en = 1'b1; load_addr = 16'h3006; load_data = 16'hBBBB;
    @(negedge clock);
    load_en = 1'b0;
    e = instr_q.pop_front();
    checks++;
    if (complete_instr !== 1'b1 || instr_dout !== e)
      $display("FAIL load_vs_fetch: got pulse=%b data=%h expected pulse=1 data=%h", complete_instr, instr_dout, e);
    else passed++;
    fetch_go(0, 16'h3006); instr_q.push_back(16'hBBBB); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || instr_dout !== e) $display("FAIL load_vs_fetch_after: got %h expected %h", instr_dout, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int n = 0;
    for (int i = 0; i < 4; i++) load(3, BA[i], BV[i]);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        checks++;
        if (complete_instr3 !== (k % 4 == 0)) $display("FAIL b2b_pulse: cycle %0d got %b expected %b", k, complete_instr3, (k % 4 == 0));
        else passed++;
        if (complete_instr3 === 1'b1 && instr3_q.size() > 0) begin
          e = instr3_q.pop_front();
          n++;
          checks++;
          if (instr_dout3 !== e) $display("FAIL b2b_data: cycle %0d got %h expected %h", k, instr_dout3, e);
          else passed++;
        end
      end
      if (k < 12) begin
        instrmem_rd3 = 1'b1;
        pc3 = (k % 4 == 0) ? BA[k / 4] : BA[3];
        if (k % 4 == 0) instr3_q.push_back(BV[k / 4]);
      end else begin
        instrmem_rd3 = 1'b0;
      end
      @(negedge clock);
    end
    checks++;
    if (n != 3 || instr3_q.size() != 0) $display("FAIL b2b_count: got %0d completions, %0d pending, expected 3, 0", n, instr3_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen; int k; logic [15:0] e;
    load(3, 16'h3020, 16'h1234);
    load(3, 16'h3021, 16'h5555);
    fetch_go(3, 16'h3021); instr3_q.push_back(16'h5555); wait_done(2, ok, k); e = instr3_q.pop_front();
    checks++;
    if (!ok || k != 3 || instr_dout3 !== e) $display("FAIL lat3_fetch: got %h after %0d expected %h after 3", instr_dout3, k, e);
    else passed++;
    data_go(3, 16'h3021, 1'b1, 16'h0000); data3_q.push_back(16'h5555); wait_done(3, ok, k); e = data3_q.pop_front();
    checks++;
    if (!ok || k != 3 || data_dout3 !== e) $display("FAIL lat3_read: got %h after %0d expected %h after 3", data_dout3, k, e);
    else passed++;
    data_go(3, 16'h3020, 1'b0, 16'h9999);
    reset3 = 1'b1;
    @(negedge clock);
    reset3 = 1'b0;
    checks++;
    if ({instr_dout3, data_dout3, complete_instr3, complete_data3, oor_err3} !== 35'd0)
      $display("FAIL reset_mid_outputs: got %h expected 0", {instr_dout3, data_dout3, complete_instr3, complete_data3, oor_err3});
    else passed++;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (complete_data3 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL reset_mid_pulse: got a completion expected none");
    else passed++;
    data_go(3, 16'h3020, 1'b1, 16'h0000); data3_q.push_back(16'h1234); wait_done(3, ok, k); e = data3_q.pop_front();
    checks++;
    if (!ok || data_dout3 !== e) $display("FAIL reset_mid_nocommit: got %h expected %h", data_dout3, e);
    else passed++;
  endtask

  task automatic test_oor();
    bit ok; int k; logic [15:0] e;
    load(0, 16'h2FFF, 16'hDEAD);
    fetch_go(0, 16'h30FF); instr_q.push_back(16'h7777); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || instr_dout !== e) $display("FAIL oor_load_dropped: got %h expected %h", instr_dout, e);
    else passed++;
    checks++;
    if (oor_err !== 1'b0) $display("FAIL oor_err_clear: got %b expected 0", oor_err);
    else passed++;
    fetch_go(0, 16'h2FFF); instr_q.push_back(OOR_WORD); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || k != 1 || instr_dout !== e) $display("FAIL oor_fetch: got %h after %0d expected %h after 1", instr_dout, k, e);
    else passed++;
    checks++;
    if (oor_err !== OOR_FLAG) $display("FAIL oor_err_set: got %b expected %b", oor_err, OOR_FLAG);
    else passed++;
    fetch_go(0, 16'h3000); instr_q.push_back(16'h1261); wait_done(0, ok, k); e = instr_q.pop_front();
    checks++;
    if (!ok || instr_dout !== e) $display("FAIL oor_inrange_after: got %h expected %h", instr_dout, e);
    else passed++;
    checks++;
    if (oor_err !== OOR_FLAG) $display("FAIL oor_err_sticky: got %b expected %b", oor_err, OOR_FLAG);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_oor();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
